// File: rtl/ram_burst_master.sv
// Burst master for a single-port RAM: one command moves len+1 beats
// between the write/read streams and consecutive (wrapping) RAM addresses.
module ram_burst_master #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wdata_valid,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ready,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              beat;

  // A beat is a write handshake or any read cycle.
  assign beat = (state_q == WRITE && wdata_valid) ||
                (state_q == READ);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_len;
          state_d     = cmd_wr ? WRITE : READ;
        end
      end
      WRITE: ;
      READ: begin
        rdata_d  = ram_dout;
        rvalid_d = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (beat) begin
      cur_addr_d  = cur_addr_q + ADDR_W'(1);
      remaining_d = remaining_q - ADDR_W'(1);
      if (remaining_q == '0) state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // Strobes are gated by rst so a reset cycle never touches the RAM.
  assign cmd_ready   = !rst && state_q == IDLE;
  assign wdata_ready = !rst && state_q == WRITE;
  assign ram_wr      = !rst && state_q == WRITE && wdata_valid;
  assign ram_rd      = !rst && state_q == READ;
  assign done        = !rst && state_q == DONE;
  assign rdata_valid = !rst && rvalid_q;
  assign rdata       = rdata_q;
  assign ram_addr    = (!rst && (state_q == WRITE || state_q == READ))
                       ? cur_addr_q : '0;
  assign ram_din     = (!rst && state_q == WRITE) ? wdata : '0;

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: directed burst table, stall/reset/busy
// sequences and random bursts against a simple memory model.
module tb_ram_burst_master;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid;
  logic [DW-1:0] rdata;
  logic          done, ram_wr, ram_rd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  wire  [DW-1:0] ram_dout;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wbuf [DEPTH];

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] wa_q[$], ra_q[$];
  logic [DW-1:0] wd_q[$], rd_q[$];
  int n_done, last_wr, first_rd, first_rv, last_rv, done_cyc;
  int busy_err, stall_err, stalls_applied;

  ram_burst_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done),
    .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_din;
  assign ram_dout = ram_rd ? mem[ram_addr] : 'z;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] wrap(input logic [AW-1:0] a, input int i);
    return AW'(int'(a) + i);
  endfunction

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Called just after a posedge; returns just after the posedge that
  // follows the DONE cycle (an IDLE cycle, ready for the next command).
  task automatic do_burst(input bit wr, input logic [AW-1:0] addr,
                          input logic [AW-1:0] len, input int stall_at,
                          input int stall_n, input bit busy);
    int  cyc, beats;
    bit  fin, stall;
    wa_q.delete(); wd_q.delete(); ra_q.delete(); rd_q.delete();
    n_done = 0; last_wr = -1; first_rd = -1; first_rv = -1;
    last_rv = -1; done_cyc = -1; busy_err = 0; stall_err = 0;
    stalls_applied = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    beats = 0; fin = 0; cyc = 0;
    while (!fin && cyc < 40) begin
      stall = wr && beats == stall_at && stalls_applied < stall_n;
      if (stall) stalls_applied++;
      wdata_valid = wr && !stall;
      wdata = wbuf[beats % DEPTH];
      cmd_valid = busy && cyc == 1;
      cmd_wr = 1'b1; cmd_addr = ~addr; cmd_len = 3'd7;
      @(negedge clk);
      if (cmd_ready) busy_err++;
      if (!wdata_valid && ram_wr) stall_err++;
      if (wdata_valid && wdata_ready) beats++;
      if (ram_wr) begin
        wa_q.push_back(ram_addr); wd_q.push_back(ram_din); last_wr = cyc;
      end
      if (ram_rd) begin
        ra_q.push_back(ram_addr);
        if (first_rd < 0) first_rd = cyc;
      end
      if (rdata_valid) begin
        rd_q.push_back(rdata);
        if (first_rv < 0) first_rv = cyc;
        last_rv = cyc;
      end
      if (done) begin n_done++; done_cyc = cyc; fin = 1; end
      @(posedge clk); #1;
      cyc++;
    end
    cmd_valid = 1'b0; wdata_valid = 1'b0;
    chk("ready_after_done", cmd_ready, 1);
    chk("done_single", done, 0);
    chk("idle_addr_din", {ram_addr, ram_din}, 0);
    chk("idle_rvalid", rdata_valid, 0);
  endtask

  task automatic check_burst(input bit wr, input logic [AW-1:0] addr,
                             input logic [AW-1:0] len);
    int errs, n;
    n = int'(len) + 1;
    errs = 0;
    chk("done_count", n_done, 1);
    chk("busy_ignored", busy_err, 0);
    if (wr) begin
      chk("wr_count", wa_q.size(), n);
      for (int i = 0; i < n && i < wa_q.size(); i++) begin
        if (wa_q[i] !== wrap(addr, i)) errs++;
        if (wd_q[i] !== wbuf[i]) errs++;
      end
      chk("wr_seq", errs, 0);
      chk("stall_no_write", stall_err, 0);
      chk("wr_done_lat", done_cyc, n + stalls_applied);
      chk("wr_done_after_last", done_cyc, last_wr + 1);
      chk("wr_no_read", ra_q.size(), 0);
      for (int i = 0; i < n; i++) ref_mem[wrap(addr, i)] = wbuf[i];
    end else begin
      chk("rd_count", ra_q.size(), n);
      chk("rvalid_count", rd_q.size(), n);
      for (int i = 0; i < n && i < ra_q.size(); i++)
        if (ra_q[i] !== wrap(addr, i)) errs++;
      for (int i = 0; i < n && i < rd_q.size(); i++)
        if (rd_q[i] !== ref_mem[wrap(addr, i)]) errs++;
      chk("rd_seq", errs, 0);
      chk("rd_first", first_rd, 0);
      chk("rd_latency", first_rv, 1);
      chk("rd_done_last_valid", done_cyc, last_rv);
      chk("rd_no_write", wa_q.size(), 0);
      chk("rdata_hold", rdata, ref_mem[wrap(addr, n - 1)]);
    end
    @(negedge clk);
    chk("mem_model", mem_diff(), 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
    logic [DW-1:0] base;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] got_f, got_l;
    vecs[0] = '{1'b1, 3'd2, 3'd3, 8'hA1, 8'hA1, 8'hA4};
    vecs[1] = '{1'b0, 3'd2, 3'd3, 8'h00, 8'hA1, 8'hA4};
    vecs[2] = '{1'b1, 3'd6, 3'd7, 8'h00, 8'h00, 8'h07};
    vecs[3] = '{1'b0, 3'd0, 3'd7, 8'h00, 8'h02, 8'h01};
    vecs[4] = '{1'b0, 3'd6, 3'd1, 8'h00, 8'h00, 8'h01};
    vecs[5] = '{1'b1, 3'd7, 3'd0, 8'h55, 8'h55, 8'h55};
    vecs[6] = '{1'b0, 3'd7, 3'd0, 8'h00, 8'h55, 8'h55};

    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
    cmd_len = '0; wdata_valid = 1'b0; wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v = DW'($urandom);
      mem[i] <= v;
      ref_mem[i] = v;
      wbuf[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {cmd_ready, wdata_ready, ram_wr, ram_rd, rdata_valid, done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", cmd_ready, 1);
    chk("reset_rdata", rdata, 0);
    chk("reset_addr", ram_addr, 0);
    @(posedge clk); #1;

    for (int t = 0; t < 7; t++) begin
      if (vecs[t].wr)
        for (int i = 0; i < DEPTH; i++) wbuf[i] = vecs[t].base + DW'(i);
      do_burst(vecs[t].wr, vecs[t].addr, vecs[t].len, 99, 0, !vecs[t].wr);
      if (vecs[t].wr) begin
        got_f = mem[vecs[t].addr];
        got_l = mem[wrap(vecs[t].addr, int'(vecs[t].len))];
      end else begin
        got_f = rd_q.size() > 0 ? rd_q[0] : 'x;
        got_l = rd_q.size() > 0 ? rd_q[rd_q.size() - 1] : 'x;
      end
      check_burst(vecs[t].wr, vecs[t].addr, vecs[t].len);
      chk($sformatf("vec%0d_first", t), got_f, vecs[t].exp_first);
      chk($sformatf("vec%0d_last", t), got_l, vecs[t].exp_last);
    end

    // Two-cycle stall between the two beats of a write.
    wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
    do_burst(1'b1, 3'd4, 3'd1, 1, 2, 1'b0);
    check_burst(1'b1, 3'd4, 3'd1);
    chk("stall_done_cyc", done_cyc, 4);
    chk("stall_writes", wa_q.size(), 2);

    // Reset after the second of four write beats.
    for (int i = 0; i < 4; i++) wbuf[i] = 8'h11 + DW'(i);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 3'd0; cmd_len = 3'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0; wdata_valid = 1'b1; wdata = wbuf[0];
    @(posedge clk); #1;
    wdata = wbuf[1];
    @(posedge clk); #1;
    rst = 1'b1; wdata = wbuf[2];
    @(negedge clk);
    chk("midrst_outputs",
        {cmd_ready, wdata_ready, ram_wr, ram_rd, rdata_valid, done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_no_write", ram_wr, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_addr", ram_addr, 0);
    @(posedge clk); #1;
    wdata_valid = 1'b0;
    ref_mem[0] = 8'h11; ref_mem[1] = 8'h12;
    n_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midrst_no_done", n_done, 0);
    chk("midrst_mem", mem_diff(), 0);
    @(posedge clk); #1;

    // Random bursts against the memory model.
    for (int r = 0; r < 30; r++) begin
      bit            rw;
      logic [AW-1:0] ra, rl;
      rw = 1'($urandom);
      ra = AW'($urandom);
      rl = AW'($urandom);
      for (int i = 0; i < DEPTH; i++) wbuf[i] = DW'($urandom);
      do_burst(rw, ra, rl, $urandom_range(0, int'(rl)),
               $urandom_range(0, 2), !rw && 1'($urandom));
      check_burst(rw, ra, rl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
